// File: rtl/ula_pkg.sv
// Opcode set shared with the ula, scheduler state encoding and the opcode legality check.
package ula_pkg;

  localparam int OP_W = 5;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_NOT = 5'd5;
  localparam logic [4:0] OP_SHL = 5'd6;
  localparam logic [4:0] OP_SHR = 5'd7;
  localparam logic [4:0] OP_MUL = 5'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHL, OP_SHR, OP_MUL: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/ula_rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or above ptr (with wrap) wins.
module ula_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [ID_W:0]   sum_s;
  logic [ID_W-1:0] cand_s;

  // Scan candidates in priority order starting at the pointer.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum_s >= (ID_W+1)'(NUM_REQ)) begin
        sum_s = sum_s - (ID_W+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[ID_W-1:0];
      if (!gnt_any && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        gnt_idx     = cand_s;
        gnt_any     = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/ula_req_scheduler.sv
// Round-robin scheduler sharing one ula between NUM_REQ requesters, one op in flight,
// with illegal-opcode rejection and a WAIT timeout.
module ula_req_scheduler
  import ula_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 16,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*5-1:0]  i_req_op,
  input  logic [NUM_REQ*16-1:0] i_req_a,
  input  logic [NUM_REQ*16-1:0] i_req_b,
  output logic [4:0]            o_ula_op,
  output logic [15:0]           o_ula_a,
  output logic [15:0]           o_ula_b,
  input  logic                  i_ula_valid,
  input  logic [31:0]           i_ula_result,
  input  logic                  i_ula_carry,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [31:0]           o_rsp_result,
  output logic                  o_rsp_carry,
  output logic                  o_rsp_error,
  input  logic                  i_rsp_ready,
  output logic                  o_busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_t        state_r;
  sched_state_t        state_nxt_s;
  logic [ID_W-1:0]     ptr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [ID_W-1:0]     id_r;
  logic [4:0]          ula_op_r;
  logic [15:0]         ula_a_r;
  logic [15:0]         ula_b_r;
  logic                rsp_valid_r;
  logic [31:0]         rsp_result_r;
  logic                rsp_carry_r;
  logic                rsp_error_r;

  logic [NUM_REQ-1:0]  gnt_s;
  logic [ID_W-1:0]     gnt_idx_s;
  logic                gnt_any_s;
  logic [4:0]          sel_op_s;
  logic [15:0]         sel_a_s;
  logic [15:0]         sel_b_s;
  logic                sel_legal_s;
  logic                timeout_s;

  ula_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (i_req_valid),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  // Payload of the arbitration winner; the grant is one-hot so an OR-mux suffices.
  always_comb begin
    sel_op_s = '0;
    sel_a_s  = '0;
    sel_b_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_op_s = sel_op_s | (i_req_op[i*5 +: 5]  & {5{gnt_s[i]}});
      sel_a_s  = sel_a_s  | (i_req_a[i*16 +: 16] & {16{gnt_s[i]}});
      sel_b_s  = sel_b_s  | (i_req_b[i*16 +: 16] & {16{gnt_s[i]}});
    end
  end

  assign sel_legal_s = is_legal_op(sel_op_s);
  assign timeout_s   = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (gnt_any_s) begin
          state_nxt_s = sel_legal_s ? S_ISSUE : S_RESP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (i_ula_valid || timeout_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Grant is offered only in IDLE, and never while reset is held.
  always_comb begin
    o_req_ready = '0;
    if ((state_r == S_IDLE) && !rst) begin
      o_req_ready = gnt_s;
    end else begin
      o_req_ready = '0;
    end
  end

  // Capture registers, timeout counter and response holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r        <= '0;
      cnt_r        <= '0;
      id_r         <= '0;
      ula_op_r     <= '0;
      ula_a_r      <= '0;
      ula_b_r      <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= '0;
      rsp_carry_r  <= 1'b0;
      rsp_error_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (gnt_any_s) begin
            id_r  <= gnt_idx_s;
            ptr_r <= (gnt_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
            // Illegal ops never reach the ula, so its inputs keep the previous op.
            if (sel_legal_s) begin
              ula_op_r <= sel_op_s;
              ula_a_r  <= sel_a_s;
              ula_b_r  <= sel_b_s;
            end else begin
              rsp_valid_r  <= 1'b1;
              rsp_result_r <= '0;
              rsp_carry_r  <= 1'b0;
              rsp_error_r  <= 1'b1;
            end
          end
        end
        S_ISSUE: cnt_r <= '0;
        S_WAIT: begin
          if (i_ula_valid) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= i_ula_result;
            rsp_carry_r  <= i_ula_carry;
            rsp_error_r  <= 1'b0;
          end else if (timeout_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= '0;
            rsp_carry_r  <= 1'b0;
            rsp_error_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cnt_r       <= '0;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_ula_op     = ula_op_r;
  assign o_ula_a      = ula_a_r;
  assign o_ula_b      = ula_b_r;
  assign o_rsp_valid  = rsp_valid_r;
  assign o_rsp_id     = id_r;
  assign o_rsp_result = rsp_result_r;
  assign o_rsp_carry  = rsp_carry_r;
  assign o_rsp_error  = rsp_error_r;
  assign o_busy       = (state_r != S_IDLE);

endmodule
